// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage stall/bubble/flush/freeze control for a 5-stage MIPS pipeline.
// Ports: clk/reset; ID/EX/MEM register fields and control bits in; PCWrite, IFIDWrite,
// IDEXBubble, IFIDFlush, FreezeAll, HazardState, MemError out.
// Optional build macro HAZARD_PERF_EN adds PerfClear in and StallCycles[15:0] out.
module hazard_stall_unit #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IFIDRS,
  input  logic [4:0] IFIDRT,
  input  logic       IFIDUsesRT,
  input  logic       IDBranch,
  input  logic       IDBranchTaken,
  input  logic       IDJump,
  input  logic [4:0] IDEXRT,
  input  logic [4:0] IDEXRD,
  input  logic       IDEXMemRead,
  input  logic       IDEXRegWrite,
  input  logic [4:0] EXMEMRD,
  input  logic       EXMEMMemRead,
  input  logic       EXMEMMemAccess,
  input  logic       MemReady,
`ifdef HAZARD_PERF_EN
  input  logic       PerfClear,
  output logic [15:0] StallCycles,
`endif
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IDEXBubble,
  output logic       IFIDFlush,
  output logic       FreezeAll,
  output logic [1:0] HazardState,
  output logic       MemError
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    BRSTALL = 2'b10,
    MEMWAIT = 2'b11
  } state_e;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic memwait, loaduse, brhaz, redirect;

  // r0 is hardwired zero, so it never carries a dependency
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  assign memwait  = EXMEMMemAccess & ~MemReady;
  assign loaduse  = IDEXMemRead &
                    (hit(IDEXRT, IFIDRS) |
                     (IFIDUsesRT & hit(IDEXRT, IFIDRT)));
  assign brhaz    = IDBranch &
                    ((IDEXRegWrite &
                      (hit(IDEXRD, IFIDRS) | hit(IDEXRD, IFIDRT))) |
                     (EXMEMMemRead &
                      (hit(EXMEMRD, IFIDRS) | hit(EXMEMRD, IFIDRT))));
  assign redirect = (IDBranch & IDBranchTaken) | IDJump;

  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXBubble = 1'b0;
    IFIDFlush  = 1'b0;
    FreezeAll  = 1'b0;
    state_d    = RUN;
    if (memwait) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      FreezeAll = 1'b1;
      state_d   = MEMWAIT;
    end else if (loaduse || brhaz) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
      state_d    = loaduse ? LDSTALL : BRSTALL;
    end else if (redirect) begin
      IFIDFlush = 1'b1;
    end
    if (reset) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
      IFIDFlush  = 1'b1;
      FreezeAll  = 1'b0;
      state_d    = RUN;
    end
  end

  // watchdog: counts consecutive wait cycles, saturating
  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if (memwait) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      if (cnt_q >= TO_LIM) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign HazardState = reset ? RUN : state_q;
  assign MemError    = reset ? 1'b0 : err_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset || PerfClear) begin
      stall_q <= '0;
    end else if (!PCWrite && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign StallCycles = stall_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed and randomized checks of hazard_stall_unit
// against a behavioural model of the hazard rules.
module tb_hazard_stall_unit;

  localparam int TO  = 3;
  localparam int TOW = 4;
  localparam int CMAX = (1 << TOW) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IFIDRS, IFIDRT, IDEXRT, IDEXRD, EXMEMRD;
  logic       IFIDUsesRT, IDBranch, IDBranchTaken, IDJump;
  logic       IDEXMemRead, IDEXRegWrite, EXMEMMemRead;
  logic       EXMEMMemAccess, MemReady;
  logic       PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, FreezeAll;
  logic [1:0] HazardState;
  logic       MemError;
`ifdef HAZARD_PERF_EN
  logic        PerfClear;
  logic [15:0] StallCycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  int m_state, m_cnt, m_perf;
  bit m_err;

  hazard_stall_unit #(.MEM_TIMEOUT(TO), .TO_W(TOW)) dut (
    .clk(clk), .reset(reset),
    .IFIDRS(IFIDRS), .IFIDRT(IFIDRT), .IFIDUsesRT(IFIDUsesRT),
    .IDBranch(IDBranch), .IDBranchTaken(IDBranchTaken), .IDJump(IDJump),
    .IDEXRT(IDEXRT), .IDEXRD(IDEXRD), .IDEXMemRead(IDEXMemRead),
    .IDEXRegWrite(IDEXRegWrite), .EXMEMRD(EXMEMRD),
    .EXMEMMemRead(EXMEMMemRead), .EXMEMMemAccess(EXMEMMemAccess),
    .MemReady(MemReady),
`ifdef HAZARD_PERF_EN
    .PerfClear(PerfClear), .StallCycles(StallCycles),
`endif
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble),
    .IFIDFlush(IFIDFlush), .FreezeAll(FreezeAll),
    .HazardState(HazardState), .MemError(MemError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
    return a != 0 && a == b;
  endfunction

  function automatic bit m_mw();
    return EXMEMMemAccess && !MemReady;
  endfunction

  function automatic bit m_lu();
    return IDEXMemRead && (dep(IDEXRT, IFIDRS) ||
           (IFIDUsesRT && dep(IDEXRT, IFIDRT)));
  endfunction

  function automatic bit m_br();
    bit alu, ld;
    alu = IDEXRegWrite && (dep(IDEXRD, IFIDRS) || dep(IDEXRD, IFIDRT));
    ld  = EXMEMMemRead && (dep(EXMEMRD, IFIDRS) || dep(EXMEMRD, IFIDRT));
    return IDBranch && (alu || ld);
  endfunction

  // reason code for this cycle: 0 run, 1 load-use, 2 branch, 3 mem wait
  function automatic int m_reason();
    if (m_mw()) return 3;
    if (m_lu()) return 1;
    if (m_br()) return 2;
    return 0;
  endfunction

  // {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, FreezeAll}
  function automatic int m_ctl();
    if (reset) return 5'b00110;
    case (m_reason())
      3: return 5'b00001;
      1, 2: return 5'b00100;
      default: return ((IDBranch && IDBranchTaken) || IDJump) ?
                       5'b11010 : 5'b11000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_state <= 0;
      m_cnt   <= 0;
      m_err   <= 0;
      m_perf  <= 0;
    end else begin
      m_state <= m_reason();
      if (m_mw()) begin
        m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
        if (m_cnt >= TO) m_err <= 1;
      end else begin
        m_cnt <= 0;
      end
`ifdef HAZARD_PERF_EN
      if (PerfClear) m_perf <= 0;
      else if (m_ctl() >= 5'b10000 == 0 && m_perf < 65535)
        m_perf <= m_perf + 1;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctl", {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, FreezeAll},
          m_ctl());
      chk("state", HazardState, reset ? 0 : m_state);
      chk("memerr", MemError, reset ? 0 : m_err);
`ifdef HAZARD_PERF_EN
      chk("stallcyc", StallCycles, m_perf);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    IFIDRS = 0; IFIDRT = 0; IFIDUsesRT = 0;
    IDBranch = 0; IDBranchTaken = 0; IDJump = 0;
    IDEXRT = 0; IDEXRD = 0; IDEXMemRead = 0; IDEXRegWrite = 0;
    EXMEMRD = 0; EXMEMMemRead = 0; EXMEMMemAccess = 0; MemReady = 1;
`ifdef HAZARD_PERF_EN
    PerfClear = 0;
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1;
    idle();
    cyc();
    chk_en = 1;
    smp();
    chk("rst_pc", PCWrite, 0);
    chk("rst_flush", IFIDFlush, 1);
    chk("rst_bub", IDEXBubble, 1);
    chk("rst_state", HazardState, 0);

    // load-use
    cyc(); reset = 0;
    IDEXMemRead = 1; IDEXRT = 5; IFIDRS = 5;
    smp();
    chk("lu_pc", PCWrite, 0);
    chk("lu_ifid", IFIDWrite, 0);
    chk("lu_bub", IDEXBubble, 1);
    cyc(); idle();
    smp();
    chk("lu_state", HazardState, 1);
    cyc(); IDEXMemRead = 1; IDEXRT = 0; IFIDRS = 0;
    smp();
    chk("r0_pc", PCWrite, 1);

    // branch after load: two stall cycles, then taken redirect
    cyc(); idle();
    IDBranch = 1; IFIDRS = 7;
    IDEXMemRead = 1; IDEXRT = 7; IDEXRD = 7; IDEXRegWrite = 1;
    smp();
    chk("brld1_pc", PCWrite, 0);
    cyc(); idle();
    IDBranch = 1; IFIDRS = 7;
    EXMEMMemRead = 1; EXMEMRD = 7; EXMEMMemAccess = 1; MemReady = 1;
    smp();
    chk("brld2_state", HazardState, 1);
    chk("brld2_pc", PCWrite, 0);
    cyc(); idle();
    IDBranch = 1; IDBranchTaken = 1; IFIDRS = 7;
    smp();
    chk("brld3_state", HazardState, 2);
    chk("brld3_flush", IFIDFlush, 1);
    chk("brld3_pc", PCWrite, 1);

    // ALU result feeding a branch
    cyc(); idle();
    IDEXRegWrite = 1; IDEXRD = 3; IDBranch = 1; IFIDRT = 3; IFIDUsesRT = 1;
    smp();
    chk("alubr_pc", PCWrite, 0);
    cyc(); idle();
    smp();
    chk("alubr_state", HazardState, 2);

    // memory wait over a pending load-use
    for (int i = 0; i < 5; i++) begin
      cyc(); idle();
      IDEXMemRead = 1; IDEXRT = 9; IFIDRS = 9;
      EXMEMMemAccess = 1; MemReady = (i == 4);
      smp();
      chk("mw_frz", FreezeAll, i < 4);
      chk("mw_bub", IDEXBubble, i == 4);
    end
    cyc(); idle(); reset = 1;
    cyc(); reset = 0;

    // timeout watchdog
    for (int i = 1; i <= 10; i++) begin
      EXMEMMemAccess = 1; MemReady = 0;
      smp();
      if (i == 4) chk("to_c4", MemError, 0);
      if (i == 5) chk("to_c5", MemError, 1);
      cyc();
    end
    MemReady = 1;
    smp();
    chk("to_sticky", MemError, 1);
    cyc(); idle(); reset = 1;
    smp();
    chk("to_rst_pc", PCWrite, 0);
    chk("to_rst_flush", IFIDFlush, 1);
    chk("to_rst_err", MemError, 0);
    cyc(); reset = 0;
    smp();
    chk("to_clr_err", MemError, 0);

`ifdef HAZARD_PERF_EN
    cyc(); PerfClear = 1;
    cyc(); PerfClear = 0;
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 3) begin
        IDEXMemRead = 1; IDEXRT = 4; IFIDRS = 4;
      end else begin
        EXMEMMemAccess = 1; MemReady = 0;
      end
      cyc();
    end
    idle(); PerfClear = 1;
    smp();
    chk("perf5", StallCycles, 5);
    cyc(); PerfClear = 0;
    smp();
    chk("perf_clr", StallCycles, 0);
`endif

    // randomized phase, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      bit slow;
      cyc();
      slow = ((i / 150) % 2) == 1;
      reset          = ($urandom_range(0, 99) == 0);
      IFIDRS         = 5'($urandom_range(0, 3));
      IFIDRT         = 5'($urandom_range(0, 3));
      IDEXRT         = 5'($urandom_range(0, 3));
      IDEXRD         = 5'($urandom_range(0, 3));
      EXMEMRD        = 5'($urandom_range(0, 3));
      IFIDUsesRT     = 1'($urandom);
      IDBranch       = 1'($urandom);
      IDBranchTaken  = 1'($urandom);
      IDJump         = ($urandom_range(0, 7) == 0);
      IDEXMemRead    = 1'($urandom);
      IDEXRegWrite   = 1'($urandom);
      EXMEMMemRead   = 1'($urandom);
      EXMEMMemAccess = slow ? 1'b1 : 1'($urandom);
      MemReady       = slow ? ($urandom_range(0, 7) == 0)
                            : ($urandom_range(0, 3) != 0);
`ifdef HAZARD_PERF_EN
      PerfClear      = ($urandom_range(0, 49) == 0);
`endif
    end
    cyc();
    smp();
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- ID-stage hazard controller for the 5-stage MIPS pipeline; produces the stall, bubble, flush and freeze controls that ForwardUnit cannot cover by bypassing.
- Handles three cases: load-use stalls, ID-resolved branch operand stalls, and data-memory wait freezes with a timeout watchdog.
- Sits beside ForwardUnit and drives PC, IF/ID, ID/EX and the EX/MEM + MEM/WB write enables.

Parameters:
- MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before MemError is set (1..65535).
- TO_W, 16, width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- IFIDRS  input  5  rs of the instruction in ID.
- IFIDRT  input  5  rt of the instruction in ID.
- IFIDUsesRT  input  1  ID instruction reads rt (R-type, beq, sw).
- IDBranch  input  1  ID instruction is beq/bne.
- IDBranchTaken  input  1  ID comparator result; meaningful only when no stall.
- IDJump  input  1  ID instruction is j/jal.
- IDEXRT  input  5  rt of the instruction in EX.
- IDEXRD  input  5  destination of the instruction in EX, after the RegDst mux.
- IDEXMemRead  input  1  EX instruction is a load.
- IDEXRegWrite  input  1  EX instruction writes a register.
- EXMEMRD  input  5  destination of the instruction in MEM.
- EXMEMMemRead  input  1  MEM instruction is a load.
- EXMEMMemAccess  input  1  MEM instruction is a load or a store.
- MemReady  input  1  data memory completes access this cycle.
- PCWrite  output  1  PC update enable.
- IFIDWrite  output  1  IF/ID register enable.
- IDEXBubble  output  1  zero the control fields loaded into ID/EX.
- IFIDFlush  output  1  squash the instruction being fetched.
- FreezeAll  output  1  hold EX/MEM and MEM/WB; also suppresses ID/EX load.
- HazardState  output  2  FSM state: 00 RUN, 01 LDSTALL, 10 BRSTALL, 11 MEMWAIT.
- MemError  output  1  sticky memory-timeout flag.

Behaviour:
- Register r0 never causes a hazard. Every comparison requires the register number to be nonzero.
- Combinational detect, evaluated every cycle:
  - memwait = EXMEMMemAccess & !MemReady.
  - loaduse = IDEXMemRead & (IDEXRT==IFIDRS | (IFIDUsesRT & IDEXRT==IFIDRT)).
  - brhaz = IDBranch & ((IDEXRegWrite & IDEXRD matches rs/rt) | (EXMEMMemRead & EXMEMRD matches rs/rt)).
- Priority: memwait > loaduse > brhaz > redirect.
- memwait:
  - Outputs: PCWrite=0, IFIDWrite=0, FreezeAll=1, IDEXBubble=0, IFIDFlush=0.
  - Next state MEMWAIT.
- loaduse or brhaz (no memwait):
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1, FreezeAll=0, IFIDFlush=0.
  - Next state LDSTALL (loaduse) or BRSTALL (brhaz only).
- Branch with a load in EX stalls 2 cycles. This falls out naturally: cycle 1 is loaduse/brhaz, cycle 2 is brhaz with the load now in MEM.
- Redirect, no hazard: (IDBranch & IDBranchTaken) | IDJump gives IFIDFlush=1, PCWrite=1, IFIDWrite=1.
- Idle (none of the above): PCWrite=1, IFIDWrite=1, all other control outputs 0. Next state RUN.
- HazardState is the registered next-state, so it shows the previous cycle's reason (1-cycle latency).
- Timeout counter:
  - Increments (saturating) each cycle memwait=1; clears when memwait=0.
  - When the count reaches MEM_TIMEOUT while memwait=1, MemError is set on the next edge.
  - MemError stays set until reset. Freeze continues while memwait holds.
- MemReady=1 in the same cycle a load-use is pending: memwait=0, so the loaduse stall applies that cycle.
- Reset, mid-operation included, takes effect on the next edge: state=RUN, counter=0, MemError=0.
- Outputs forced while reset=1: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=1, FreezeAll=0, HazardState=00, MemError=0.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - Adds output StallCycles[15:0], a saturating count of cycles with PCWrite=0 and reset=0. Saturates at 16'hFFFF.
  - Adds input PerfClear; PerfClear=1 zeroes the count on the next edge and has priority over increment.
  - Reset value 0.
- Undefined: ports absent, no counter logic.

Test Plan:
- Load-use: IDEXMemRead=1, IDEXRT=5, IFIDRS=5 -> same cycle PCWrite=0, IFIDWrite=0, IDEXBubble=1; next cycle HazardState=01. With IDEXRT=0 -> no stall.
- Branch after load: IDBranch=1, IFIDRS=7, load to r7 in EX -> 2 stall cycles with HazardState 01 then 10. Third cycle with IDBranchTaken=1 -> IFIDFlush=1, PCWrite=1.
- ALU-to-branch: IDEXRegWrite=1, IDEXRD=3, IDBranch=1, IFIDRT=3, IFIDUsesRT=1 -> 1-cycle stall, HazardState=10.
- Memory wait: EXMEMMemAccess=1, MemReady=0 for 4 cycles with a simultaneous load-use -> FreezeAll=1, IDEXBubble=0 for 4 cycles. MemReady=1 -> FreezeAll=0 and loaduse stall that cycle.
- Timeout: MEM_TIMEOUT=3, memwait held 10 cycles -> MemError=1 after cycle 4 and stays 1 after MemReady=1. Synchronous reset clears it and forces PCWrite=0, IFIDFlush=1 during reset.
- HAZARD_PERF_EN: run 3 load-use stalls and 2 wait cycles -> StallCycles=5. PerfClear pulse -> 0 next edge.
